// File: rtl/bitmanip_issue_ctrl_if.sv
// Shared types and handshake interface for the bit-manipulation issue stage.
// bitmanip_issue_pkg carries the op encoding and fu_data_t record that travel
// toward bit_extension.
// bitmanip_issue_ctrl_if groups the upstream issue handshake with the
// writeback result handshake.

package bitmanip_issue_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  // Operator encoding seen by bit_extension; ADD is the idle/rest value.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    XORL = 4'd1,
    CLZ  = 4'd2,
    CTZ  = 4'd3,
    PCNT = 4'd4,
    PACK = 4'd5,
    BEXT = 4'd6,
    BDEP = 4'd7
  } fu_op_t;

  typedef struct packed {
    fu_op_t                   operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

endpackage

interface bitmanip_issue_ctrl_if #(
  parameter int unsigned TRANS_ID_BITS = bitmanip_issue_pkg::TRANS_ID_BITS
);
  import bitmanip_issue_pkg::*;

  // issue side
  logic                     bm_valid;
  logic                     bm_ready;
  fu_data_t                 fu_data;
  // writeback side
  logic [63:0]              result;
  logic [TRANS_ID_BITS-1:0] trans_id;
  logic                     result_valid;
  logic                     result_ready;

  // upstream issuer / writeback consumer view
  modport master (
    output bm_valid, fu_data, result_ready,
    input  bm_ready, result, trans_id, result_valid
  );

  // issue controller view
  modport slave (
    input  bm_valid, fu_data, result_ready,
    output bm_ready, result, trans_id, result_valid
  );
endinterface

// File: rtl/bitmanip_issue_ctrl.sv
// bitmanip_issue_ctrl: issue/sequencing stage in front of bit_extension.
// Single-cycle ops are captured into the 1-deep result register on the accept
// edge. BEXT/BDEP ops are latched and held on bext_fu_data_o for MC_CYCLES
// cycles, then the multi-cycle result is captured.
// Optional feature macro: BITMANIP_PERF_CNT_EN adds the perf_single_o,
// perf_multi_o and perf_stall_o counters.

module bitmanip_issue_ctrl
  import bitmanip_issue_pkg::*;
#(
  parameter int unsigned MC_CYCLES     = 2,
  parameter int unsigned TRANS_ID_BITS = bitmanip_issue_pkg::TRANS_ID_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  bitmanip_issue_ctrl_if.slave bm_if,
  output fu_data_t             bext_fu_data_o,
  input  logic [63:0]          bext_result_i,
  input  logic [63:0]          bext_mc_result_i
`ifdef BITMANIP_PERF_CNT_EN
  ,
  output logic [31:0]          perf_single_o,
  output logic [31:0]          perf_multi_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned      CNT_W    = $clog2(MC_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ops that need operands held for the multi-cycle window.
  function automatic logic is_multi_cycle(input fu_op_t op);
    logic mc;
    case (op)
      BEXT:    mc = 1'b1;
      BDEP:    mc = 1'b1;
      default: mc = 1'b0;
    endcase
    return mc;
  endfunction

  state_t                   state_r, state_n_s;
  logic [CNT_W-1:0]         cnt_r, cnt_n_s;
  fu_data_t                 op_q_r, op_q_n_s;
  logic [63:0]              result_r, result_n_s;
  logic [TRANS_ID_BITS-1:0] trans_id_r, trans_id_n_s;
  logic                     valid_r, valid_n_s;

  logic                     out_free_s;
  logic                     bm_ready_s;
  logic                     accept_s;
  logic                     in_is_mc_s;
  logic                     cnt_done_s;
  logic                     cap_single_s;
  logic                     cap_multi_s;
  fu_data_t                 bext_fu_s;

  assign out_free_s = !valid_r | bm_if.result_ready;
  // Nothing is accepted while reset is held.
  assign bm_ready_s = rst_ni & (state_r == IDLE) & out_free_s & !flush_i;
  assign accept_s   = bm_if.bm_valid & bm_ready_s;
  assign in_is_mc_s = is_multi_cycle(bm_if.fu_data.operator);
  assign cnt_done_s = (cnt_r == CNT_LAST);

  // Next-state, output-register and operand-hold decisions.
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    op_q_n_s     = op_q_r;
    result_n_s   = result_r;
    trans_id_n_s = trans_id_r;
    valid_n_s    = valid_r & !bm_if.result_ready;
    cap_single_s = 1'b0;
    cap_multi_s  = 1'b0;
    bext_fu_s    = bm_if.fu_data;

    case (state_r)
      IDLE: begin
        // Without a valid op, bit_extension sees ADD so its multi-cycle
        // machinery stays at rest.
        if (bm_if.bm_valid) begin
          bext_fu_s = bm_if.fu_data;
        end else begin
          bext_fu_s.operator = ADD;
        end
        if (accept_s) begin
          if (in_is_mc_s) begin
            op_q_n_s  = bm_if.fu_data;
            cnt_n_s   = CNT_W'(1'b1);
            state_n_s = BUSY;
          end else begin
            result_n_s   = bext_result_i;
            trans_id_n_s = TRANS_ID_BITS'(bm_if.fu_data.trans_id);
            valid_n_s    = 1'b1;
            cap_single_s = 1'b1;
          end
        end else begin
          cnt_n_s = '0;
        end
      end
      BUSY: begin
        bext_fu_s = op_q_r;
        if (cnt_done_s) begin
          result_n_s         = bext_mc_result_i;
          trans_id_n_s       = TRANS_ID_BITS'(op_q_r.trans_id);
          valid_n_s          = 1'b1;
          cap_multi_s        = 1'b1;
          op_q_n_s.operator  = ADD;
          cnt_n_s            = '0;
          state_n_s          = IDLE;
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        bext_fu_s.operator = ADD;
        cnt_n_s            = '0;
        state_n_s          = IDLE;
      end
    endcase

    // Flush kills the in-flight op and any pending result.
    if (flush_i) begin
      state_n_s         = IDLE;
      cnt_n_s           = '0;
      valid_n_s         = 1'b0;
      op_q_n_s.operator = ADD;
      cap_single_s      = 1'b0;
      cap_multi_s       = 1'b0;
    end else begin
      state_n_s = state_n_s;
    end
  end

  // State, counter, held op and result register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_q_r     <= '0;
      result_r   <= 64'd0;
      trans_id_r <= '0;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      cnt_r      <= cnt_n_s;
      op_q_r     <= op_q_n_s;
      result_r   <= result_n_s;
      trans_id_r <= trans_id_n_s;
      valid_r    <= valid_n_s;
    end
  end

  assign bext_fu_data_o     = bext_fu_s;
  assign bm_if.bm_ready     = bm_ready_s;
  assign bm_if.result       = result_r;
  assign bm_if.trans_id     = trans_id_r;
  assign bm_if.result_valid = valid_r;

`ifdef BITMANIP_PERF_CNT_EN
  logic [31:0] perf_single_r;
  logic [31:0] perf_multi_r;
  logic [31:0] perf_stall_r;
  logic        stall_s;

  assign stall_s = bm_if.bm_valid & !bm_ready_s;

  // Completion and stall counters; free-running, untouched by flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_single_r <= 32'd0;
      perf_multi_r  <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      perf_single_r <= cap_single_s ? perf_single_r + 32'd1 : perf_single_r;
      perf_multi_r  <= cap_multi_s  ? perf_multi_r  + 32'd1 : perf_multi_r;
      perf_stall_r  <= stall_s      ? perf_stall_r  + 32'd1 : perf_stall_r;
    end
  end

  assign perf_single_o = perf_single_r;
  assign perf_multi_o  = perf_multi_r;
  assign perf_stall_o  = perf_stall_r;
`endif

endmodule

// File: tb/tb_bitmanip_issue_ctrl.sv
// Directed bench for bitmanip_issue_ctrl with a behavioural bit_extension stub.
// The stub only returns a valid BEXT/BDEP result when the same op was
// presented on the previous cycle too, so operand hold is exercised.
module tb_bitmanip_issue_ctrl;
  import bitmanip_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush;
  fu_data_t    bext_fu;
  fu_data_t    prev_fu_q;
  logic [63:0] bext_result;
  logic [63:0] bext_mc_result;
  int          errors = 0;
  int          checks = 0;
`ifdef BITMANIP_PERF_CNT_EN
  logic [31:0] perf_single, perf_multi, perf_stall;
  logic [31:0] snap_single, snap_multi;
`endif

  always #5 clk = ~clk;

  bitmanip_issue_ctrl_if bm_if ();

  bitmanip_issue_ctrl #(.MC_CYCLES(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush),
    .bm_if            (bm_if),
    .bext_fu_data_o   (bext_fu),
    .bext_result_i    (bext_result),
    .bext_mc_result_i (bext_mc_result)
`ifdef BITMANIP_PERF_CNT_EN
    ,
    .perf_single_o    (perf_single),
    .perf_multi_o     (perf_multi),
    .perf_stall_o     (perf_stall)
`endif
  );

  // ---------------- bit_extension stub ----------------
  function automatic logic [63:0] cnt_lz(input logic [63:0] v);
    logic [63:0] n = 64'd0;
    logic found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else n = n + 64'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] cnt_tz(input logic [63:0] v);
    logic [63:0] n = 64'd0;
    logic found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else n = n + 64'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] stub_single(input fu_data_t d);
    case (d.operator)
      ADD:     return d.operand_a + d.operand_b;
      CLZ:     return cnt_lz(d.operand_a);
      CTZ:     return cnt_tz(d.operand_a);
      PCNT:    return 64'($countones(d.operand_a));
      PACK:    return {d.operand_b[31:0], d.operand_a[31:0]};
      default: return d.operand_a ^ d.operand_b;
    endcase
  endfunction

  function automatic logic [63:0] stub_multi(input fu_data_t d);
    logic [63:0] r = 64'd0;
    int k = 0;
    for (int i = 0; i < 64; i++) begin
      if (d.operand_b[i]) begin
        if (d.operator == BEXT) r[k] = d.operand_a[i];
        else r[i] = d.operand_a[k];
        k++;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) prev_fu_q <= bext_fu;

  always_comb begin
    bext_result = stub_single(bext_fu);
    if ((bext_fu.operator == BEXT || bext_fu.operator == BDEP) && bext_fu == prev_fu_q)
      bext_mc_result = stub_multi(bext_fu);
    else
      bext_mc_result = 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] id, input logic v);
    @(negedge clk);
    bm_if.bm_valid           = v;
    bm_if.fu_data.operator   = op;
    bm_if.fu_data.operand_a  = a;
    bm_if.fu_data.operand_b  = b;
    bm_if.fu_data.trans_id   = id;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [63:0] r,
                         input logic [2:0] id);
    chk({name, "_valid"}, 64'(bm_if.result_valid), 64'(v));
    chk({name, "_result"}, bm_if.result, r);
    chk({name, "_id"}, 64'(bm_if.trans_id), 64'(id));
  endtask

  typedef struct {
    fu_op_t      op;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  id;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{PCNT, 64'hFF,                  64'h0,                  3'd2, 64'd8};
    vecs[1] = '{CLZ,  64'h1,                   64'h0,                  3'd3, 64'd63};
    vecs[2] = '{CTZ,  64'h100,                 64'h0,                  3'd4, 64'd8};
    vecs[3] = '{PACK, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 3'd5, 64'h7777_8888_3333_4444};
    vecs[4] = '{XORL, 64'hF0,                  64'h0F,                 3'd6, 64'hFF};
    vecs[5] = '{ADD,  64'h5,                   64'h7,                  3'd7, 64'd12};
    vecs[6] = '{CLZ,  64'h0,                   64'h0,                  3'd0, 64'd64};
    vecs[7] = '{CTZ,  64'h0,                   64'h0,                  3'd1, 64'd64};
    vecs[8] = '{PCNT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  3'd2, 64'd64};
    vecs[9] = '{CTZ,  64'h8000_0000_0000_0000, 64'h0,                  3'd3, 64'd63};

    // reset held 3 cycles with an op offered
    rst_ni = 1'b0;
    flush  = 1'b0;
    bm_if.result_ready      = 1'b1;
    bm_if.bm_valid          = 1'b1;
    bm_if.fu_data.operator  = PCNT;
    bm_if.fu_data.operand_a = 64'hFF;
    bm_if.fu_data.operand_b = 64'h0;
    bm_if.fu_data.trans_id  = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 64'(bm_if.result_valid), 64'd0);
      chk("rst_ready", 64'(bm_if.bm_ready), 64'd0);
    end
    chk("rst_result", bm_if.result, 64'd0);
    chk("rst_id", 64'(bm_if.trans_id), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    bm_if.bm_valid = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bm_if.bm_ready), 64'd1);
    tick();
    chk("post_rst_valid", 64'(bm_if.result_valid), 64'd0);

    // single-cycle ops, back to back
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].id, 1'b1);
      chk("tbl_ready", 64'(bm_if.bm_ready), 64'd1);
      tick();
      chk_out("tbl", 1'b1, vecs[i].exp, vecs[i].id);
    end

    // idle presentation forces ADD, result drains
    drive(PCNT, 64'hFF, 64'h0, 3'd0, 1'b0);
    chk("idle_op_add", 64'(bext_fu.operator), 64'(ADD));
    chk("idle_opa_pass", bext_fu.operand_a, 64'hFF);
    tick();
    chk("drain_valid", 64'(bm_if.result_valid), 64'd0);

    // BEXT: one busy cycle, operands held despite new input
    drive(BEXT, 64'hF0F0, 64'hFF00, 3'd5, 1'b1);
    chk("bext_ready", 64'(bm_if.bm_ready), 64'd1);
    tick();
    chk("bext_busy_ready", 64'(bm_if.bm_ready), 64'd0);
    chk("bext_busy_valid", 64'(bm_if.result_valid), 64'd0);
    chk("bext_hold_a", bext_fu.operand_a, 64'hF0F0);
    drive(PCNT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd6, 1'b1);
    chk("bext_stall_ready", 64'(bm_if.bm_ready), 64'd0);
    chk("bext_hold_op", 64'(bext_fu.operator), 64'(BEXT));
    tick();
    chk_out("bext", 1'b1, 64'hF0, 3'd5);
    chk("after_mc_ready", 64'(bm_if.bm_ready), 64'd1);
    tick();
    chk_out("after_mc", 1'b1, 64'd64, 3'd6);
    drive(ADD, 64'h0, 64'h0, 3'd0, 1'b0);
    tick();
    chk("after_mc_drain", 64'(bm_if.result_valid), 64'd0);

    // BDEP
    drive(BDEP, 64'hA5, 64'hF0F0, 3'd1, 1'b1);
    tick();
    drive(ADD, 64'h0, 64'h0, 3'd0, 1'b0);
    tick();
    chk_out("bdep", 1'b1, 64'hA050, 3'd1);
    tick();
    chk("bdep_drain", 64'(bm_if.result_valid), 64'd0);

    // backpressure: result held, issue blocked, release accepts same cycle
    @(negedge clk);
    bm_if.result_ready = 1'b0;
    drive(PCNT, 64'hFF, 64'h0, 3'd7, 1'b1);
    tick();
    chk_out("bp_first", 1'b1, 64'd8, 3'd7);
    drive(CLZ, 64'h1, 64'h0, 3'd0, 1'b1);
    chk("bp_ready", 64'(bm_if.bm_ready), 64'd0);
    tick();
    chk_out("bp_hold1", 1'b1, 64'd8, 3'd7);
    tick();
    chk_out("bp_hold2", 1'b1, 64'd8, 3'd7);
    @(negedge clk);
    bm_if.result_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bm_if.bm_ready), 64'd1);
    tick();
    chk_out("bp_replace", 1'b1, 64'd63, 3'd0);
    drive(ADD, 64'h0, 64'h0, 3'd0, 1'b0);
    tick();
    chk("bp_drain", 64'(bm_if.result_valid), 64'd0);

    // flush during BDEP busy; PACK offered in the flush cycle is refused
    drive(BDEP, 64'hA5, 64'hF0F0, 3'd2, 1'b1);
    tick();
    chk("fl_busy_ready", 64'(bm_if.bm_ready), 64'd0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    drive(PACK, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 3'd3, 1'b1);
    chk("fl_ready", 64'(bm_if.bm_ready), 64'd0);
    tick();
    chk("fl_no_valid", 64'(bm_if.result_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_idle_ready", 64'(bm_if.bm_ready), 64'd1);
    chk("fl_idle_op", 64'(bext_fu.operator), 64'(PACK));
    tick();
    chk_out("fl_pack", 1'b1, 64'h7777_8888_3333_4444, 3'd3);
    drive(ADD, 64'h0, 64'h0, 3'd0, 1'b0);
    tick();
    chk("fl_no_late", 64'(bm_if.result_valid), 64'd0);

`ifdef BITMANIP_PERF_CNT_EN
    snap_single = perf_single;
    snap_multi  = perf_multi;
    for (int i = 0; i < 3; i++) begin
      drive(PCNT, 64'hFF, 64'h0, 3'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(BEXT, 64'hF0F0, 64'hFF00, 3'd4, 1'b1);
      tick();
      drive(ADD, 64'h0, 64'h0, 3'd0, 1'b0);
      tick();
    end
    drive(BDEP, 64'hA5, 64'hF0F0, 3'd5, 1'b1);
    tick();
    @(negedge clk);
    flush = 1'b1;
    bm_if.bm_valid = 1'b0;
    tick();
    @(negedge clk);
    flush = 1'b0;
    tick();
    chk("perf_single", 64'(perf_single - snap_single), 64'd3);
    chk("perf_multi", 64'(perf_multi - snap_multi), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
